// File: rtl/sequenciador_operacao_if.sv
// Command/decoder-select bundle between the upstream issuer and the operation sequencer.
// Handshake: a command transfers on a rising edge where cmd_valid=1 and cmd_ready=1;
// the issuer holds cmd_valid/cmd_op stable until that edge, and cmd_ready depends on sequencer state only.
interface sequenciador_operacao_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       cancelar;
  logic [1:0] op_sel;
  logic       op_ativo;
  logic       fim;
  logic [7:0] contador_ops;

  modport master (
    output cmd_valid, cmd_op, cancelar,
    input  cmd_ready, op_sel, op_ativo, fim, contador_ops
  );

  modport slave (
    input  cmd_valid, cmd_op, cancelar,
    output cmd_ready, op_sel, op_ativo, fim, contador_ops
  );
endinterface

// File: rtl/sequenciador_operacao.sv
// Holds one decoder operation active for a per-opcode number of cycles, then pulses fim
// and counts it; cancelar aborts a running operation without counting it.
module sequenciador_operacao #(
  parameter int unsigned LAT0 = 1,
  parameter int unsigned LAT1 = 1,
  parameter int unsigned LAT2 = 2,
  parameter int unsigned LAT3 = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  sequenciador_operacao_if.slave        s_bus,
  output logic [1:0]                    o_estado
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    EXEC   = 2'd1,
    FIM    = 2'd2
  } estado_t;

  // A latency of 0 behaves as 1, so the loaded count saturates at 0.
  function automatic logic [3:0] lat_m1(input int unsigned lat);
    if (lat == 0) return 4'd0;
    else          return 4'(lat - 1);
  endfunction

  localparam logic [3:0] CNT0 = lat_m1(LAT0);
  localparam logic [3:0] CNT1 = lat_m1(LAT1);
  localparam logic [3:0] CNT2 = lat_m1(LAT2);
  localparam logic [3:0] CNT3 = lat_m1(LAT3);

  estado_t    r_estado;
  estado_t    w_prox;
  logic [1:0] r_op_sel;
  logic [3:0] r_cnt;
  logic [7:0] r_contador;
  logic       w_ready;
  logic       w_aceita;
  logic [3:0] w_cnt_carga;

  assign w_ready  = (r_estado != EXEC);
  assign w_aceita = s_bus.cmd_valid && w_ready;

  always_comb begin
    w_cnt_carga = CNT0;
    case (s_bus.cmd_op)
      2'd0:    w_cnt_carga = CNT0;
      2'd1:    w_cnt_carga = CNT1;
      2'd2:    w_cnt_carga = CNT2;
      default: w_cnt_carga = CNT3;
    endcase
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO: if (w_aceita) w_prox = EXEC;
      // Cancel takes priority over reaching the end of the count.
      EXEC: begin
        if (s_bus.cancelar)   w_prox = OCIOSO;
        else if (r_cnt == '0) w_prox = FIM;
      end
      FIM:     w_prox = w_aceita ? EXEC : OCIOSO;
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado   <= OCIOSO;
      r_op_sel   <= 2'd0;
      r_cnt      <= 4'd0;
      r_contador <= 8'd0;
    end else begin
      r_estado <= w_prox;
      if (w_aceita) begin
        r_op_sel <= s_bus.cmd_op;
        r_cnt    <= w_cnt_carga;
      end else if (r_estado == EXEC && !s_bus.cancelar && r_cnt != '0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_estado == FIM) r_contador <= r_contador + 8'd1;
    end
  end

  assign s_bus.cmd_ready    = w_ready;
  assign s_bus.op_sel       = r_op_sel;
  assign s_bus.op_ativo     = (r_estado == EXEC);
  assign s_bus.fim          = (r_estado == FIM);
  assign s_bus.contador_ops = r_contador;
  assign o_estado           = r_estado;

endmodule

// File: tb/tb_sequenciador_operacao.sv
// Directed bench for sequenciador_operacao: reset, single/back-to-back ops, cancel,
// async reset mid-operation and counter wrap.
module tb_sequenciador_operacao;

  logic       clk;
  logic       rst;
  logic [1:0] estado;
  int         total;
  int         bad;
  logic [7:0] exp_cnt;
  logic [7:0] exp_q[$];

  sequenciador_operacao_if bus();

  sequenciador_operacao #(
    .LAT0(1), .LAT1(1), .LAT2(2), .LAT3(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_bus    (bus.slave),
    .o_estado (estado)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // exp: 0 idle, 1 exec, 2 fim
  task automatic chk_state(input string tag, input int st, input logic [1:0] op);
    chk({tag, ".op_ativo"},  {7'd0, bus.op_ativo},  (st == 1) ? 8'd1 : 8'd0);
    chk({tag, ".fim"},       {7'd0, bus.fim},       (st == 2) ? 8'd1 : 8'd0);
    chk({tag, ".cmd_ready"}, {7'd0, bus.cmd_ready}, (st == 1) ? 8'd0 : 8'd1);
    chk({tag, ".op_sel"},    {6'd0, bus.op_sel},    {6'd0, op});
    chk({tag, ".cnt_ops"},   bus.contador_ops,      exp_cnt);
    chk({tag, ".estado"},    {6'd0, estado},        8'(st));
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_cnt = 8'd0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'd0;
    bus.cancelar = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // reset state held with no commands
    for (int i = 0; i < 5; i++) begin
      chk_state("reset_idle", 0, 2'd0);
      tick();
    end

    // single opcode 11, LAT3=4
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'd3;
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_state("op11_exec", 1, 2'd3);
      tick();
    end
    chk_state("op11_fim", 2, 2'd3);
    tick();
    exp_cnt = 8'd1;
    chk_state("op11_done", 0, 2'd3);

    // back-to-back 00,10,01 with valid held high
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd2);
    exp_q.push_back(8'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'd0;
    tick();
    bus.cmd_op = 2'd2;
    chk_state("b2b_op00_exec", 1, exp_q[0][1:0]);
    tick();
    chk_state("b2b_op00_fim", 2, exp_q[0][1:0]);
    void'(exp_q.pop_front());
    tick();
    exp_cnt = 8'd2;
    bus.cmd_op = 2'd1;
    chk_state("b2b_op10_exec0", 1, exp_q[0][1:0]);
    tick();
    chk_state("b2b_op10_exec1", 1, exp_q[0][1:0]);
    tick();
    chk_state("b2b_op10_fim", 2, exp_q[0][1:0]);
    void'(exp_q.pop_front());
    tick();
    exp_cnt = 8'd3;
    bus.cmd_valid = 1'b0;
    chk_state("b2b_op01_exec", 1, exp_q[0][1:0]);
    tick();
    chk_state("b2b_op01_fim", 2, exp_q[0][1:0]);
    void'(exp_q.pop_front());
    tick();
    exp_cnt = 8'd4;
    chk_state("b2b_done", 0, 2'd1);
    chk("b2b_queue_empty", 8'(exp_q.size()), 8'd0);

    // cancel opcode 10 in first exec cycle, then immediate new accept
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'd2;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cancelar = 1'b1;
    chk_state("cancel_exec", 1, 2'd2);
    tick();
    bus.cancelar = 1'b0;
    chk_state("cancel_idle", 0, 2'd2);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'd1;
    tick();
    bus.cmd_valid = 1'b0;
    chk_state("after_cancel_exec", 1, 2'd1);
    tick();
    chk_state("after_cancel_fim", 2, 2'd1);
    tick();
    exp_cnt = 8'd5;
    chk_state("after_cancel_done", 0, 2'd1);

    // cancel on the cycle the count is already 0 (opcode 00): no fim
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'd0;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cancelar = 1'b1;
    chk_state("cancel_last_exec", 1, 2'd0);
    tick();
    bus.cancelar = 1'b0;
    chk_state("cancel_last_idle", 0, 2'd0);

    // cancelar ignored during fim
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'd0;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    bus.cancelar = 1'b1;
    chk_state("cancel_in_fim", 2, 2'd0);
    tick();
    bus.cancelar = 1'b0;
    exp_cnt = 8'd6;
    chk_state("cancel_in_fim_done", 0, 2'd0);

    // async reset between edges during exec
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'd3;
    tick();
    bus.cmd_valid = 1'b0;
    chk_state("rst_pre", 1, 2'd3);
    #2;
    rst = 1'b1;
    #1;
    exp_cnt = 8'd0;
    chk_state("rst_async", 0, 2'd0);
    #1;
    rst = 1'b0;
    tick();
    chk_state("rst_after_edge", 0, 2'd0);
    tick();
    chk_state("rst_after_edge2", 0, 2'd0);

    // 256 opcode-00 operations: wrap of contador_ops
    for (int i = 0; i < 256; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op = 2'd0;
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      tick();
      exp_cnt = exp_cnt + 8'd1;
      if (i == 254) chk("wrap_255", bus.contador_ops, 8'd255);
      if (i == 255) chk("wrap_0", bus.contador_ops, 8'd0);
      if (i % 32 == 0) chk("wrap_progress", bus.contador_ops, exp_cnt);
    end
    chk_state("wrap_end", 0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
